// File: rtl/lif_neuron_layer.sv
// Four-neuron leaky integrate-and-fire stage: collects four MVM row words, updates one
// membrane per cycle with shift-based leak, and hands a 4-bit spike train over valid/ready.
module lif_neuron_layer #(
  parameter int LEAK_SHIFT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_val,
  input  logic       in_toggle,
  input  logic [7:0] threshold,
  input  logic       clear_state,
  output logic [3:0] spike_out,
  output logic       spike_valid,
  input  logic       spike_ready,
  output logic [7:0] ts_count,
  output logic       overrun,
  output logic       busy
);

  typedef enum logic [1:0] {COLLECT, UPDATE, EMIT} state_t;

  state_t     state;
  logic [7:0] v      [4];
  logic [7:0] in_buf [4];
  logic [1:0] wcnt;
  logic [1:0] nidx;
  logic [3:0] spk_acc;
  logic       tog_q;
  logic       word;
  logic [7:0] cur_v;
  logic [7:0] leak;
  logic [8:0] sum9;
  logic [7:0] sum_sat;
  logic       fire;

  assign word = (in_toggle != tog_q);

  // v - leak never exceeds 255, so adding an 8-bit word fits in 9 bits.
  always_comb begin
    cur_v   = v[nidx];
    leak    = cur_v >> LEAK_SHIFT;
    sum9    = {1'b0, cur_v} - {1'b0, leak} + {1'b0, in_buf[nidx]};
    sum_sat = sum9[8] ? 8'hFF : sum9[7:0];
    fire    = (sum_sat >= threshold);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= COLLECT;
      wcnt        <= '0;
      nidx        <= '0;
      spk_acc     <= '0;
      tog_q       <= 1'b0;
      spike_out   <= '0;
      spike_valid <= 1'b0;
      ts_count    <= '0;
      overrun     <= 1'b0;
      busy        <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        v[i]      <= '0;
        in_buf[i] <= '0;
      end
    end else begin
      tog_q <= in_toggle;
      if (clear_state) begin
        state       <= COLLECT;
        wcnt        <= '0;
        nidx        <= '0;
        overrun     <= 1'b0;
        spike_valid <= 1'b0;
        busy        <= 1'b0;
        for (int i = 0; i < 4; i++) v[i] <= '0;
      end else begin
        case (state)
          COLLECT: begin
            if (word) begin
              in_buf[wcnt] <= in_val;
              wcnt         <= wcnt + 2'd1;
              if (wcnt == 2'd3) begin
                state <= UPDATE;
                busy  <= 1'b1;
                nidx  <= '0;
              end
            end
          end
          UPDATE: begin
            if (word) overrun <= 1'b1;
            spk_acc[nidx] <= fire;
            v[nidx]       <= fire ? 8'd0 : sum_sat;
            nidx          <= nidx + 2'd1;
            if (nidx == 2'd3) begin
              state       <= EMIT;
              spike_out   <= {fire, spk_acc[2:0]};
              spike_valid <= 1'b1;
            end
          end
          EMIT: begin
            if (word) overrun <= 1'b1;
            if (spike_ready) begin
              spike_valid <= 1'b0;
              ts_count    <= ts_count + 8'd1;
              busy        <= 1'b0;
              state       <= COLLECT;
            end
          end
          default: begin
            state <= COLLECT;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lif_neuron_layer.sv
// Self-checking bench for lif_neuron_layer: directed test-plan cases plus random timesteps
// against an integer membrane model.
module tb_lif_neuron_layer;
  localparam int LS = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_val = '0;
  logic       in_toggle = 1'b0;
  logic [7:0] threshold = '0;
  logic       clear_state = 1'b0;
  logic [3:0] spike_out;
  logic       spike_valid;
  logic       spike_ready = 1'b0;
  logic [7:0] ts_count;
  logic       overrun;
  logic       busy;

  int n_checks = 0;
  int n_fail = 0;
  int mv[4];
  int ts_exp = 0;
  int ov_exp = 0;

  lif_neuron_layer #(.LEAK_SHIFT(LS)) dut (
    .clk(clk), .rst_n(rst_n), .in_val(in_val), .in_toggle(in_toggle),
    .threshold(threshold), .clear_state(clear_state), .spike_out(spike_out),
    .spike_valid(spike_valid), .spike_ready(spike_ready), .ts_count(ts_count),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_zero();
    for (int i = 0; i < 4; i++) mv[i] = 0;
  endtask

  // Integer LIF model: leak by division, saturate, fire-and-reset.
  function automatic int model_step(input int w0, w1, w2, w3, input int thr);
    int w[4];
    int s;
    int spk;
    w = '{w0, w1, w2, w3};
    spk = 0;
    for (int n = 0; n < 4; n++) begin
      s = mv[n] - mv[n] / (1 << LS) + w[n];
      if (s > 255) s = 255;
      if (s >= thr) begin
        spk += (1 << n);
        mv[n] = 0;
      end else mv[n] = s;
    end
    return spk;
  endfunction

  task automatic send_word(input int w);
    @(negedge clk);
    in_val = w[7:0];
    in_toggle = ~in_toggle;
  endtask

  task automatic send4(input int w0, w1, w2, w3);
    send_word(w0); send_word(w1); send_word(w2); send_word(w3);
  endtask

  // Waits after the 4th word for spike_valid; latency counted in negedges after capture edge.
  task automatic wait_valid(input string tag);
    int cyc;
    cyc = 0;
    @(negedge clk);
    chk({tag, "_busy"}, int'(busy), 1);
    while (!spike_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_latency"}, cyc, 4);
  endtask

  task automatic transfer(input string tag, input int exp_spk);
    chk({tag, "_spike"}, int'(spike_out), exp_spk);
    spike_ready = 1'b1;
    @(negedge clk);
    spike_ready = 1'b0;
    ts_exp = (ts_exp + 1) % 256;
    chk({tag, "_valid_low"}, int'(spike_valid), 0);
    chk({tag, "_ts"}, int'(ts_count), ts_exp);
    chk({tag, "_busy_low"}, int'(busy), 0);
  endtask

  task automatic timestep(input string tag, input int w0, w1, w2, w3, input int thr);
    int e;
    threshold = thr[7:0];
    e = model_step(w0, w1, w2, w3, thr);
    send4(w0, w1, w2, w3);
    wait_valid(tag);
    transfer(tag, e);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_spike_out"}, int'(spike_out), 0);
    chk({tag, "_spike_valid"}, int'(spike_valid), 0);
    chk({tag, "_ts"}, int'(ts_count), 0);
    chk({tag, "_overrun"}, int'(overrun), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    int e;
    int held_spk;
    model_zero();
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Test-plan sequence at threshold 100
    timestep("tp1", 50, 0, 120, 255, 100);
    chk("tp1_model", mv[0], 50);
    timestep("tp2", 60, 0, 0, 0, 100);
    chk("tp2_model", mv[0], 98);
    timestep("tp3", 10, 0, 0, 0, 100);
    chk("tp3_model", mv[0], 84);

    // Clear membranes, then saturation case at threshold 255
    @(negedge clk); clear_state = 1'b1;
    @(negedge clk); clear_state = 1'b0;
    model_zero();
    chk("clr_ts_kept", int'(ts_count), ts_exp);
    timestep("sat1", 200, 0, 0, 0, 255);
    timestep("sat2", 200, 0, 0, 0, 255);
    timestep("thr0", 0, 0, 0, 0, 0);

    // Backpressure: hold ready low in EMIT while two words arrive
    threshold = 8'd90;
    e = model_step(95, 10, 89, 200, 90);
    send4(95, 10, 89, 200);
    wait_valid("bp");
    held_spk = e;
    for (int c = 0; c < 10; c++) begin
      if (c == 2 || c == 5) send_word(77);
      else @(negedge clk);
      chk("bp_valid_held", int'(spike_valid), 1);
      chk("bp_spike_held", int'(spike_out), held_spk);
    end
    ov_exp = 1;
    chk("bp_overrun", int'(overrun), ov_exp);
    transfer("bp", held_spk);
    timestep("bp_after", 30, 40, 50, 60, 90);
    chk("bp_overrun_sticky", int'(overrun), 1);

    // Reset while UPDATE is part way through
    threshold = 8'd100;
    send4(150, 150, 150, 150);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    in_toggle = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_zero();
    ts_exp = 0;
    ov_exp = 0;
    timestep("postrst", 90, 99, 100, 101, 100);

    // clear_state after two words discards the partial timestep
    send_word(250);
    send_word(250);
    @(negedge clk); clear_state = 1'b1;
    @(negedge clk); clear_state = 1'b0;
    model_zero();
    chk("clr_ts", int'(ts_count), ts_exp);
    chk("clr_overrun", int'(overrun), 0);
    timestep("postclr", 20, 110, 5, 99, 100);

    // Random timesteps
    for (int k = 0; k < 12; k++) begin
      timestep("rnd", int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 255)));
    end
    chk("final_overrun", int'(overrun), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/lif_neuron_layer.md
# lif_neuron_layer

Four-neuron leaky integrate-and-fire (LIF) stage that sits directly downstream of the sparse MVM accelerator. It consumes the four 8-bit row results the accelerator emits per timestep, signalled by a level toggle per word. It integrates them into per-neuron membrane potentials with shift-based leak, thresholds them, and produces a 4-bit spike train per timestep. That train is handed to the CPU/next layer over a valid/ready handshake and is the value later loaded back as the accelerator's spike-train input.

## Interface
- LEAK_SHIFT, 2 — leak = V >> LEAK_SHIFT per timestep; legal 1..7.
- clk  in  1  — single clock, all state on posedge.
- rst_n  in  1  — reset, asynchronous and active-low; clears all state.
- in_val  in  8  — row result word from MVM (unsigned).
- in_toggle  in  1  — each level change marks one new in_val word.
- threshold  in  8  — firing threshold (unsigned); sampled during UPDATE.
- clear_state  in  1  — synchronous pulse: zero membranes, word count, and overrun.
- spike_out  out  4  — bit i = neuron i fired this timestep; reset 0.
- spike_valid  out  1  — spike_out holds a timestep result; reset 0.
- spike_ready  in  1  — consumer accepts spike_out.
- ts_count  out  8  — completed (transferred) timesteps, wraps 255→0; reset 0.
- overrun  out  1  — sticky: a word arrived outside COLLECT; reset 0.
- busy  out  1  — high in UPDATE/EMIT; reset 0.

## Operation
- States: COLLECT (reset state), UPDATE, EMIT.
- Word detect: tog_q registers in_toggle (reset 0); a word is present at an edge where in_toggle != tog_q.
- COLLECT: a present word is stored in in_buf[wcnt] and wcnt increments. The word with wcnt==3 moves to UPDATE with wcnt←0. Word i maps to neuron i.
- UPDATE: one neuron per cycle, n = 0..3:
  - sum = V[n] − (V[n] >> LEAK_SHIFT) + in_buf[n], computed at 9 bits and saturated to 255.
  - If sum ≥ threshold: spike bit n←1 and V[n]←0. Otherwise spike bit n←0 and V[n]←sum.
  - threshold==0 ⇒ every neuron fires.
  - After n=3, go to EMIT.
- EMIT: spike_valid=1 and spike_out stable. At an edge with spike_ready=1: spike_valid←0, ts_count+1, go to COLLECT.
- Words present in UPDATE or EMIT, including the transfer edge, are dropped and set overrun. They do not advance wcnt.
- clear_state takes priority over all activity:
  - V[*]←0, wcnt←0, overrun←0, spike_valid←0, state←COLLECT.
  - ts_count is kept.
  - tog_q still tracks in_toggle.
- Reset (any time, including mid-UPDATE/EMIT): all registers, outputs, and membranes←0; state←COLLECT.
- Two toggles on consecutive edges = two words; the producer guarantees in_val is valid on the edge it toggles.

## Timing
- 4th word captured at edge E. Neuron n updated at edge E+1+n. spike_valid rises after edge E+4.
- Minimum timestep period: 4 word edges + 4 UPDATE + 1 EMIT edge.
- spike_out changes only on entry to EMIT. It must not change while spike_valid=1.
- busy is registered and mirrors state (UPDATE or EMIT).

## Test plan
- LEAK_SHIFT=2, threshold=100. Words 50,0,120,255 → spike_out=4'b1100, V = {50,0,0,0}, ts_count=1 after ready.
- Continuing the same case, words 60,0,0,0 → V0 = 50−12+60 = 98, spike_out=0000. Then words 10,0,0,0 → V0 = 98−24+10 = 84, no spike.
- threshold=255, words 200 twice to neuron 0 (other words 0) → second timestep: 200−50+200 saturates to 255, fires, V0=0.
- Hold spike_ready=0 for 10 cycles in EMIT while toggling 2 words → spike_valid and spike_out stable, overrun=1, wcnt=0. After ready, 4 fresh words complete a normal timestep.
- Deassert rst_n during UPDATE (after neuron 1) → all outputs 0 immediately. Next 4 words start from V=0.
- Pulse clear_state after 2 words → wcnt=0. The next 4 words form a full timestep, and ts_count is unchanged by the clear.
